// File: rtl/qsum.sv
// Queue reducer: sums and counts each innermost sub-transaction of a dti queue.
// Latency: result valid the cycle after the eot[0] item is accepted.
// Backpressure: a held result stalls din; releasing it lets a new item in that same cycle.
module qsum #(
  parameter int W_DIN  = 16,
  parameter int W_DOUT = 24,
  parameter int W_CNT  = 16,
  parameter int LVL    = 1,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_vld,
  output logic                          din_rdy,
  input  logic [W_DIN+LVL-1:0]          din_dat,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic [W_DOUT+W_CNT+LVL-2:0]   dout_dat
);

  localparam int W_O = W_DOUT + W_CNT + LVL - 1;

  localparam logic [0:0] ACC = 1'b0;
  localparam logic [0:0] OUT = 1'b1;

  localparam logic [W_DOUT-1:0] UMAX = {W_DOUT{1'b1}};
  localparam logic [W_DOUT-1:0] SMAX = {1'b0, {(W_DOUT-1){1'b1}}};
  localparam logic [W_DOUT-1:0] SMIN = {1'b1, {(W_DOUT-1){1'b0}}};
  localparam logic [W_CNT-1:0]  CMAX = {W_CNT{1'b1}};

  logic [0:0]        state;
  logic [W_DOUT-1:0] acc;
  logic [W_CNT-1:0]  cnt;
  logic              clamped;   // frame has saturated; sum frozen until frame end

  logic              hs_i;
  logic              hs_o;
  logic              eot0;
  logic [W_DIN-1:0]  data;
  logic              ext_bit;
  logic              acc_bit;
  logic [W_DOUT:0]   a_ext;
  logic [W_DOUT:0]   d_ext;
  logic [W_DOUT:0]   sum_full;
  logic              ovf_hi;
  logic              ovf_lo;
  logic [W_DOUT-1:0] sum_nxt;
  logic              clamped_nxt;
  logic [W_CNT-1:0]  cnt_nxt;
  logic [W_O-1:0]    result;

  assign data     = din_dat[W_DIN-1:0];
  assign eot0     = din_dat[W_DIN];
  assign dout_vld = (state == OUT);
  assign hs_o     = dout_vld && dout_rdy;
  assign din_rdy  = (state == ACC) || hs_o;
  assign hs_i     = din_vld && din_rdy;

  // Add the incoming sample one bit wider than the sum so overflow is visible, then clamp or wrap.
  // acc and clamped are always zero while a result is held, so the same path starts a new frame.
  always_comb begin
    ext_bit     = (SIGNED != 0) && data[W_DIN-1];
    acc_bit     = (SIGNED != 0) && acc[W_DOUT-1];
    d_ext       = {{(W_DOUT+1-W_DIN){ext_bit}}, data};
    a_ext       = {acc_bit, acc};
    sum_full    = a_ext + d_ext;
    ovf_hi      = 1'b0;
    ovf_lo      = 1'b0;
    if (SIGNED != 0) begin
      ovf_hi = !sum_full[W_DOUT] &&  sum_full[W_DOUT-1];
      ovf_lo =  sum_full[W_DOUT] && !sum_full[W_DOUT-1];
    end else begin
      ovf_hi = sum_full[W_DOUT];
    end
    sum_nxt     = sum_full[W_DOUT-1:0];
    clamped_nxt = clamped;
    if (clamped) begin
      sum_nxt = acc;
    end else if ((SAT != 0) && ovf_hi) begin
      sum_nxt     = (SIGNED != 0) ? SMAX : UMAX;
      clamped_nxt = 1'b1;
    end else if ((SAT != 0) && ovf_lo) begin
      sum_nxt     = SMIN;
      clamped_nxt = 1'b1;
    end
    cnt_nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
  end

  // Outer eot bits ride along only with the closing item of the innermost frame.
  if (LVL > 1) begin : g_eot
    assign result = {din_dat[W_DIN+LVL-1:W_DIN+1], cnt_nxt, sum_nxt};
  end else begin : g_noeot
    assign result = {cnt_nxt, sum_nxt};
  end

  // Accumulate, close a frame into the output register, or release a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      clamped  <= 1'b0;
      dout_dat <= '0;
    end else if (hs_i) begin
      if (eot0) begin
        dout_dat <= result;
        acc      <= '0;
        cnt      <= '0;
        clamped  <= 1'b0;
        state    <= OUT;
      end else begin
        acc      <= sum_nxt;
        cnt      <= cnt_nxt;
        clamped  <= clamped_nxt;
        state    <= ACC;
      end
    end else if (hs_o) begin
      state <= ACC;
    end
  end

endmodule

// File: tb/tb_qsum.sv
// Scoreboard bench for qsum: default unsigned instance, signed saturating/wrapping pair, LVL=2 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected results are queued when stimulus is driven and popped when a result is observed.
module tb_qsum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // default instance: W_DIN 16, W_DOUT 24, W_CNT 16, LVL 1, unsigned, wrap
  logic        m_in_vld, m_in_rdy, m_out_vld, m_out_rdy;
  logic [16:0] m_in_dat;
  logic [39:0] m_out_dat;
  logic [39:0] m_q[$];

  // signed 8-bit pair sharing one input stream
  logic        s_in_vld, s_out_rdy;
  logic [8:0]  s_in_dat;
  logic        sat_in_rdy, sat_out_vld, wrp_in_rdy, wrp_out_vld;
  logic [23:0] sat_out_dat, wrp_out_dat;
  logic [23:0] sat_q[$];
  logic [23:0] wrp_q[$];

  // two-level queue instance
  logic        l_in_vld, l_in_rdy, l_out_vld, l_out_rdy;
  logic [17:0] l_in_dat;
  logic [40:0] l_out_dat;
  logic [40:0] l_q[$];

  qsum u_main (
    .clk(clk), .rst(rst),
    .din_vld(m_in_vld), .din_rdy(m_in_rdy), .din_dat(m_in_dat),
    .dout_vld(m_out_vld), .dout_rdy(m_out_rdy), .dout_dat(m_out_dat)
  );

  qsum #(.W_DIN(8), .W_DOUT(8), .W_CNT(16), .LVL(1), .SIGNED(1), .SAT(1)) u_sat (
    .clk(clk), .rst(rst),
    .din_vld(s_in_vld), .din_rdy(sat_in_rdy), .din_dat(s_in_dat),
    .dout_vld(sat_out_vld), .dout_rdy(s_out_rdy), .dout_dat(sat_out_dat)
  );

  qsum #(.W_DIN(8), .W_DOUT(8), .W_CNT(16), .LVL(1), .SIGNED(1), .SAT(0)) u_wrp (
    .clk(clk), .rst(rst),
    .din_vld(s_in_vld), .din_rdy(wrp_in_rdy), .din_dat(s_in_dat),
    .dout_vld(wrp_out_vld), .dout_rdy(s_out_rdy), .dout_dat(wrp_out_dat)
  );

  qsum #(.LVL(2)) u_l2 (
    .clk(clk), .rst(rst),
    .din_vld(l_in_vld), .din_rdy(l_in_rdy), .din_dat(l_in_dat),
    .dout_vld(l_out_vld), .dout_rdy(l_out_rdy), .dout_dat(l_out_dat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_out_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", m_out_vld); else n_pass++;
    n_chk++;
    if (m_out_dat !== 40'h0) $display("FAIL reset_dat: got %h expected 0", m_out_dat); else n_pass++;
    n_chk++;
    if (m_in_rdy !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", m_in_rdy); else n_pass++;
    n_chk++;
    if ({sat_out_vld, wrp_out_vld, l_out_vld} !== 3'b000)
      $display("FAIL reset_vld_others: got %b expected 000", {sat_out_vld, wrp_out_vld, l_out_vld});
    else n_pass++;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] vals[3] = '{16'd3, 16'd5, 16'd7};
    logic [39:0] exp;
    m_out_rdy = 1'b1;
    m_q.push_back({16'd3, 24'd15});
    for (int i = 0; i < 3; i++) begin
      m_in_vld = 1'b1;
      m_in_dat = {(i == 2), vals[i]};
      @(negedge clk);
      n_chk++;
      if (m_out_vld !== 1'b0) $display("FAIL basic_early_vld[%0d]: got %b expected 0", i, m_out_vld); else n_pass++;
      step();
    end
    m_in_vld = 1'b0;
    @(negedge clk);
    exp = m_q.pop_front();
    n_chk++;
    if (m_out_vld !== 1'b1 || m_out_dat !== exp)
      $display("FAIL basic_result: got vld=%b dat=%h expected vld=1 dat=%h", m_out_vld, m_out_dat, exp);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++;
    if (m_out_vld !== 1'b0) $display("FAIL basic_vld_drop: got %b expected 0", m_out_vld); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[3] = '{16'd4, 16'd9, 16'd1};
    logic [39:0] exp;
    m_out_rdy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        m_in_vld = 1'b1;
        m_in_dat = {1'b1, vals[i]};
        m_q.push_back({16'd1, 8'd0, vals[i]});
      end else begin
        m_in_vld = 1'b0;
      end
      @(negedge clk);
      if (i < 3) begin
        n_chk++;
        if (m_in_rdy !== 1'b1) $display("FAIL b2b_rdy[%0d]: got %b expected 1", i, m_in_rdy); else n_pass++;
      end
      if (i > 0) begin
        exp = m_q.pop_front();
        n_chk++;
        if (m_out_vld !== 1'b1 || m_out_dat !== exp)
          $display("FAIL b2b_result[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, m_out_vld, m_out_dat, exp);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] hold;
    logic [39:0] exp;
    m_out_rdy = 1'b0;
    m_q.push_back({16'd2, 24'd10});
    m_in_vld = 1'b1;
    m_in_dat = {1'b0, 16'd4};
    step();
    m_in_dat = {1'b1, 16'd6};
    step();
    m_in_dat = {1'b1, 16'd8};
    m_q.push_back({16'd1, 24'd8});
    hold = m_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (m_out_vld !== 1'b1 || m_out_dat !== hold)
        $display("FAIL bp_hold[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, m_out_vld, m_out_dat, hold);
      else n_pass++;
      n_chk++;
      if (m_in_rdy !== 1'b0) $display("FAIL bp_stall[%0d]: got %b expected 0", i, m_in_rdy); else n_pass++;
      step();
    end
    m_out_rdy = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m_in_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b expected 1", m_in_rdy); else n_pass++;
    step();
    m_in_vld = 1'b0;
    @(negedge clk);
    exp = m_q.pop_front();
    n_chk++;
    if (m_out_vld !== 1'b1 || m_out_dat !== exp)
      $display("FAIL bp_next: got vld=%b dat=%h expected vld=1 dat=%h", m_out_vld, m_out_dat, exp);
    else n_pass++;
    step();
  endtask

  task automatic test_signed_sat();
    logic [8:0]  seq[5] = '{9'h064, 9'h064, 9'h1CE, 9'h09C, 9'h19C};
    logic [23:0] exp_s;
    logic [23:0] exp_w;
    s_out_rdy = 1'b1;
    // 100+100-50: clamps at 127 and stays; wrapping gives 150-256 = -106
    sat_q.push_back({16'd3, 8'd127});
    wrp_q.push_back({16'd3, 8'h96});
    // -100-100: clamps at -128; wrapping gives -200+256 = 56
    sat_q.push_back({16'd2, 8'h80});
    wrp_q.push_back({16'd2, 8'h38});
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        s_in_vld = 1'b1;
        s_in_dat = seq[i];
      end else begin
        s_in_vld = 1'b0;
      end
      @(negedge clk);
      if (i < 5) begin
        n_chk++;
        if ({sat_in_rdy, wrp_in_rdy} !== 2'b11)
          $display("FAIL signed_rdy[%0d]: got %b expected 11", i, {sat_in_rdy, wrp_in_rdy});
        else n_pass++;
      end
      if (i == 3 || i == 5) begin
        exp_s = sat_q.pop_front();
        exp_w = wrp_q.pop_front();
        n_chk++;
        if (sat_out_vld !== 1'b1 || sat_out_dat !== exp_s)
          $display("FAIL signed_sat[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, sat_out_vld, sat_out_dat, exp_s);
        else n_pass++;
        n_chk++;
        if (wrp_out_vld !== 1'b1 || wrp_out_dat !== exp_w)
          $display("FAIL signed_wrap[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, wrp_out_vld, wrp_out_dat, exp_w);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_lvl2();
    logic [17:0] seq[3] = '{{2'b00, 16'd1}, {2'b01, 16'd2}, {2'b11, 16'd3}};
    logic [40:0] exp;
    l_out_rdy = 1'b1;
    l_q.push_back({1'b0, 16'd2, 24'd3});
    l_q.push_back({1'b1, 16'd1, 24'd3});
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        l_in_vld = 1'b1;
        l_in_dat = seq[i];
      end else begin
        l_in_vld = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        exp = l_q.pop_front();
        n_chk++;
        if (l_out_vld !== 1'b1 || l_out_dat !== exp)
          $display("FAIL lvl2_result[%0d]: got vld=%b dat=%h expected vld=1 dat=%h", i, l_out_vld, l_out_dat, exp);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    logic [39:0] exp;
    m_out_rdy = 1'b1;
    m_in_vld  = 1'b1;
    m_in_dat  = {1'b0, 16'd10};
    step();
    m_in_dat  = {1'b0, 16'd20};
    step();
    m_in_vld  = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m_out_vld !== 1'b0) $display("FAIL rst_during_vld: got %b expected 0", m_out_vld); else n_pass++;
    step();
    rst      = 1'b0;
    m_in_vld = 1'b1;
    m_in_dat = {1'b1, 16'd6};
    m_q.push_back({16'd1, 24'd6});
    @(negedge clk);
    n_chk++;
    if (m_out_vld !== 1'b0) $display("FAIL rst_after_vld: got %b expected 0", m_out_vld); else n_pass++;
    step();
    m_in_vld = 1'b0;
    @(negedge clk);
    exp = m_q.pop_front();
    n_chk++;
    if (m_out_vld !== 1'b1 || m_out_dat !== exp)
      $display("FAIL rst_result: got vld=%b dat=%h expected vld=1 dat=%h", m_out_vld, m_out_dat, exp);
    else n_pass++;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    m_in_vld  = 1'b0; m_in_dat = '0; m_out_rdy = 1'b1;
    s_in_vld  = 1'b0; s_in_dat = '0; s_out_rdy = 1'b1;
    l_in_vld  = 1'b0; l_in_dat = '0; l_out_rdy = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_signed_sat();
    test_lvl2();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
